// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR unit for the RV32I core.
// Implements the Zicsr read/modify/write ops, trap entry, mret, and
// timer/external interrupt arbitration, plus 64-bit cycle/instret counters.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_inst, i_wdata, i_csr_en          decoded CSR instruction and rs1 value
//   o_rdata, o_csr_illegal             old CSR value / illegal access (comb.)
//   i_instret                          instruction retired this cycle
//   i_exc_valid, i_exc_cause, i_cur_pc synchronous exception request
//   i_irq_ok, i_mret                   interruptible boundary, mret in execute
//   i_timer_irq, i_ext_irq             level interrupt lines
//   o_redirect_valid, o_redirect_pc    registered one-cycle PC redirect
module csr_unit #(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_wdata,
    input  logic        i_csr_en,
    output logic [31:0] o_rdata,
    output logic        o_csr_illegal,
    input  logic        i_instret,
    input  logic        i_exc_valid,
    input  logic [3:0]  i_exc_cause,
    input  logic [31:0] i_cur_pc,
    input  logic        i_irq_ok,
    input  logic        i_mret,
    input  logic        i_timer_irq,
    input  logic        i_ext_irq,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc
);

    logic        r_mie, r_mpie, r_mtie, r_meie, r_mtip, r_meip;
    logic [29:0] r_mtvec_base;
    logic [1:0]  r_mtvec_mode;
    logic [31:0] r_mscratch;
    logic [29:0] r_mepc;
    logic        r_mcause_int;
    logic [3:0]  r_mcause_code;
    logic [63:0] r_mcycle, r_minstret;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic [11:0] w_addr;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [31:0] w_src, w_old, w_new, w_trap_target;
    logic        w_known, w_ro, w_wr_req, w_illegal, w_csr_we;
    logic        w_irq_e, w_irq_t, w_trap, w_trap_int, w_do_mret;
    logic [3:0]  w_trap_code;
    logic        w_unused;

    assign w_addr   = i_inst[31:20];
    assign w_funct3 = i_inst[14:12];
    assign w_rs1    = i_inst[19:15];
    assign w_src    = w_funct3[2] ? {27'b0, w_rs1} : i_wdata;
    assign w_unused = ^{i_inst[11:0], i_cur_pc[1:0]};

    // Current CSR value by address; unknown addresses read 0 and flag illegal.
    always_comb begin
        w_old   = '0;
        w_known = 1'b1;
        w_ro    = 1'b0;
        case (w_addr)
            12'h300: w_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            12'h304: w_old = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
            12'h305: w_old = {r_mtvec_base, r_mtvec_mode};
            12'h340: w_old = r_mscratch;
            12'h341: w_old = {r_mepc, 2'b00};
            12'h342: w_old = {r_mcause_int, 27'b0, r_mcause_code};
            12'h344: w_old = {20'b0, r_meip, 3'b0, r_mtip, 7'b0};
            12'hB00: w_old = r_mcycle[31:0];
            12'hB80: w_old = r_mcycle[63:32];
            12'hB02: w_old = r_minstret[31:0];
            12'hB82: w_old = r_minstret[63:32];
            12'hF14: begin
                w_old = HART_ID;
                w_ro  = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_new = w_old;
        case (w_funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    // RS/RC with rs1/zimm == 0 are pure reads.
    assign w_wr_req  = i_csr_en && (w_funct3[1:0] != 2'b00) &&
                       ((w_funct3[1:0] == 2'b01) || (w_rs1 != 5'd0));
    assign w_illegal = i_csr_en && (!w_known || (w_ro && w_wr_req));

    assign o_rdata       = i_csr_en ? w_old : '0;
    assign o_csr_illegal = w_illegal;

    // Event arbitration: exception > external > timer > mret > csr write.
    assign w_irq_e     = r_mie && r_meie && r_meip && i_irq_ok;
    assign w_irq_t     = r_mie && r_mtie && r_mtip && i_irq_ok;
    assign w_trap      = i_exc_valid || w_irq_e || w_irq_t;
    assign w_trap_int  = !i_exc_valid && (w_irq_e || w_irq_t);
    assign w_trap_code = i_exc_valid ? i_exc_cause : (w_irq_e ? 4'd11 : 4'd7);
    assign w_do_mret   = i_mret && !w_trap;
    assign w_csr_we    = w_wr_req && !w_illegal && !w_trap && !i_mret;

    assign w_trap_target = {r_mtvec_base, 2'b00} +
        ((r_mtvec_mode == 2'b01 && w_trap_int) ? {26'b0, w_trap_code, 2'b00} : 32'b0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mie            <= 1'b0;
            r_mpie           <= 1'b0;
            r_mtie           <= 1'b0;
            r_meie           <= 1'b0;
            r_mtip           <= 1'b0;
            r_meip           <= 1'b0;
            r_mtvec_base     <= MTVEC_RESET[31:2];
            r_mtvec_mode     <= MTVEC_RESET[1:0];
            r_mscratch       <= '0;
            r_mepc           <= '0;
            r_mcause_int     <= 1'b0;
            r_mcause_code    <= '0;
            r_mcycle         <= '0;
            r_minstret       <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_mtip <= i_timer_irq;
            r_meip <= i_ext_irq;

            r_redirect_valid <= w_trap || w_do_mret;
            if (w_trap)
                r_redirect_pc <= w_trap_target;
            else if (w_do_mret)
                r_redirect_pc <= {r_mepc, 2'b00};

            // Free-running increments; a CSR write below replaces them.
            if (COUNTERS_EN) begin
                r_mcycle <= r_mcycle + 64'd1;
                if (i_instret)
                    r_minstret <= r_minstret + 64'd1;
            end

            if (w_trap) begin
                r_mepc        <= i_cur_pc[31:2];
                r_mcause_int  <= w_trap_int;
                r_mcause_code <= w_trap_code;
                r_mpie        <= r_mie;
                r_mie         <= 1'b0;
            end else if (w_do_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_csr_we) begin
                case (w_addr)
                    12'h300: begin
                        r_mie  <= w_new[3];
                        r_mpie <= w_new[7];
                    end
                    12'h304: begin
                        r_mtie <= w_new[7];
                        r_meie <= w_new[11];
                    end
                    12'h305: begin
                        r_mtvec_base <= w_new[31:2];
                        r_mtvec_mode <= w_new[1] ? 2'b00 : w_new[1:0];
                    end
                    12'h340: r_mscratch <= w_new;
                    12'h341: r_mepc <= w_new[31:2];
                    12'h342: begin
                        r_mcause_int  <= w_new[31];
                        r_mcause_code <= w_new[3:0];
                    end
                    12'hB00: if (COUNTERS_EN) r_mcycle   <= {r_mcycle[63:32], w_new};
                    12'hB80: if (COUNTERS_EN) r_mcycle   <= {w_new, r_mcycle[31:0]};
                    12'hB02: if (COUNTERS_EN) r_minstret <= {r_minstret[63:32], w_new};
                    12'hB82: if (COUNTERS_EN) r_minstret <= {w_new, r_minstret[31:0]};
                    default: ;
                endcase
            end
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control/status register unit for the RV32I core; the parametrised successor to the six-entry CSR store. It adds the full Zicsr op set, trap entry with mret return, and interrupt arbitration for timer and external interrupts. It also provides 64-bit cycle/instret counters. It sits beside the execute stage: the datapath supplies the decoded instruction and rs1 value, and the unit returns the old CSR value plus a registered PC redirect.

## Interface
- HART_ID, 0, value returned by mhartid (0xF14)
- MTVEC_RESET, 32'h0, reset value of mtvec
- COUNTERS_EN, 1, 1 = mcycle/minstret present; 0 = both read 0 and ignore writes
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst  in  32  instruction; csr addr = inst[31:20], funct3 = inst[14:12], rs1/zimm = inst[19:15]
- wdata  in  32  rs1 register value
- csr_en  in  1  valid CSR instruction in execute this cycle
- rdata  out  32  old CSR value (combinational)
- csr_illegal  out  1  combinational; unknown address, or write to read-only CSR
- instret  in  1  one instruction retired this cycle
- exc_valid  in  1  synchronous exception request
- exc_cause  in  4  exception code
- cur_pc  in  32  PC of the instruction at the trap boundary
- irq_ok  in  1  pipeline at an interruptible boundary
- mret  in  1  mret in execute
- timer_irq, ext_irq  in  1 each  level interrupt lines
- redirect_valid  out  1  registered one-cycle pulse
- redirect_pc  out  32  registered target, valid with redirect_valid

## Operation
- CSR map:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 2'b11; other bits read 0.
  - mie 0x304: MTIE[7], MEIE[11].
  - mtvec 0x305: BASE[31:2], MODE[1:0]; MODE values 2 and 3 are written as 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: bit31 is the interrupt flag; bits[3:0] are the code.
  - mip 0x344: MTIP[7] and MEIP[11] are registered copies of timer_irq and ext_irq, read-only. Writes to mip are ignored and are legal.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - mhartid 0xF14: read-only.
- funct3 ops: src = wdata for 001/010/011, zero-extended zimm for 101/110/111.
  - RW (001/101): new = src.
  - RS (010/110): new = old | src.
  - RC (011/111): new = old & ~src.
- RS/RC with inst[19:15]==0 perform no write and are never illegal on read-only CSRs.
- RW to a read-only CSR raises csr_illegal and performs no write.
- csr_illegal=1 suppresses the write. It does not trap internally; the datapath feeds it back as exc_valid (cause 2) on the next cycle.
- Counters: mcycle increments every cycle; minstret increments when instret=1. A CSR write to either half overrides that cycle's increment for the whole 64-bit counter. Wrap-around from 2^64-1 to 0.
- Interrupt pending:
  - irq_t = MIE & MTIE & MTIP.
  - irq_e = MIE & MEIE & MEIP.
  - An interrupt is taken only when irq_ok=1.
- Event priority (one per cycle): exc_valid > ext irq (cause 11) > timer irq (cause 7) > mret > csr write. A lower event in the same cycle is dropped; the datapath must replay it.
- Trap entry:
  - mepc = cur_pc & ~3.
  - mcause = {interrupt, 27'b0, code}.
  - MPIE = MIE, then MIE = 0.
  - redirect_pc = BASE<<2, or (BASE<<2) + 4*code when MODE=1 and the trap is an interrupt.
- mret: MIE = MPIE, MPIE = 1, redirect_pc = mepc.

## Timing
- Reset values:
  - All CSRs 0, except mtvec = MTVEC_RESET.
  - mip bits 0.
  - redirect_valid 0, redirect_pc 0.
- rdata and csr_illegal are combinational in the same cycle as csr_en. rdata shows the pre-write value; when csr_en=0, rdata = 0.
- CSR writes are visible on rdata from the cycle after the edge.
- redirect_valid and redirect_pc rise one edge after trap/mret acceptance and stay high for exactly one cycle.
- mip sampling adds 1 cycle of latency: an irq line asserted in cycle N can be taken in cycle N+1 at the earliest.
- Back-to-back: a trap in the cycle directly after a redirect is allowed. MIE is already 0, so only exceptions can be taken then.
- rst asserted mid-trap: state returns to reset values at that edge, and no redirect pulse is emitted.

## Test plan
- Reset, then csrrs x0-style read (rs1=0) of mtvec with MTVEC_RESET=32'h100 -> rdata=32'h100, csr_illegal=0, no write.
- csrrw mscratch with wdata=32'hDEADBEEF, then csrrc zimm=5'h0F -> second read returns 32'hDEADBEEF; next read returns 32'hDEADBEE0.
- csrrw mhartid -> csr_illegal=1 and value unchanged. Read of address 0x7C0 -> csr_illegal=1.
- Interrupt entry:
  - Setup: mtvec=32'h201 (vectored), mie=32'h800, MIE=1.
  - Stimulus: ext_irq=1, irq_ok=1, cur_pc=32'h44.
  - Required: redirect_pc=32'h22C, mepc=32'h44, mcause=32'h8000000B, MIE=0, MPIE=1.
  - Then mret -> redirect_pc=32'h44, MIE=1.
- Same-cycle exc_valid (cause 2) and timer irq pending -> mcause=32'h2, redirect_pc=BASE, and the timer stays pending.
- mcycle preload 32'hFFFFFFFF via 0xB00 -> two cycles later mcycle=1 and mcycleh=1. minstret is unchanged while instret=0.
